// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries between memory and IF/ID.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; flush empties in one cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_dat  write one 64-bit entry at the tail
//   pop, pop_dat    pop_dat always shows the head; pop advances it
//   flush           discard all entries (wins over push/pop)
//   count           current number of entries, 0..DEPTH
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = cnt_width(DEPTH),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [63:0]   push_dat,
  input  logic          pop,
  output logic [63:0]   pop_dat,
  input  logic          flush,
  output logic [CW-1:0] count
);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & (count != CW'(DEPTH));
  assign pop_ok  = pop & (count != '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap explicitly so DEPTH need not be a power of two.
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, issues word fetches, buffers responses, drives IF/ID.
// Latency: grant in cycle N -> response N+1 -> valid_o high in N+3; 1 inst/cycle steady.
// Backpressure: pause freezes IF/ID; requests stop once outstanding + buffered reach FIFO_DEPTH.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   pause                            decode stall, holds IF/ID and the FIFO head
//   br_taken, br_target              decode redirect (ignored while pause=1)
//   imem_req, imem_addr, imem_gnt    request channel, addr held until granted
//   imem_rvalid, imem_rdata          in-order response channel
//   inst_o, pc_o, valid_o            IF/ID pipeline register
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;      // address belonging to the next kept response
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credit_sum;
  logic          redirect;
  logic          fire;
  logic          drop_now;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_pc;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [63:0]   head_raw;

  assign redirect    = br_taken & ~pause;
  assign redirect_pc = br_target & 32'hFFFF_FFFC;

  // Every granted request is guaranteed a FIFO slot, so the FIFO cannot overflow.
  assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign imem_req   = ~rst & ~redirect & (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign imem_addr  = pc;
  assign fire       = imem_req & imem_gnt;

  // Responses to requests issued before a redirect are counted off and discarded.
  assign drop_now   = imem_rvalid & (drop_cnt != '0);
  assign push       = imem_rvalid & ~drop_now & ~redirect;
  assign pop        = ~pause & ~redirect & (fifo_cnt != '0);

  // Responses return in order, so the PC of each kept response is rebuilt
  // by stepping from the last redirect (or reset) target.
  assign push_entry = '{pc: resp_pc, inst: imem_rdata};
  assign head       = fetch_entry_t'(head_raw);

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head_raw),
    .flush    (redirect),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect)  pc <= redirect_pc;
      else if (fire) pc <= pc + 32'd4;

      if (redirect)  resp_pc <= redirect_pc;
      else if (push) resp_pc <= resp_pc + 32'd4;

      case ({fire, imem_rvalid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      // A response landing in the redirect cycle is already discarded, so it
      // is not counted among the ones still to drop.
      if (redirect)      drop_cnt <= outstanding - CW'(imem_rvalid);
      else if (drop_now) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o  <= NOP_INST;
      pc_o    <= '0;
      valid_o <= 1'b0;
    end else if (redirect) begin
      inst_o  <= NOP_INST;
      valid_o <= 1'b0;
    end else if (!pause) begin
      if (fifo_cnt != '0) begin
        inst_o  <= head.inst;
        pc_o    <= head.pc;
        valid_o <= 1'b1;
      end else begin
        inst_o  <= NOP_INST;
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch with a queue-based model of memory and fetch stream.
// Latency: n/a.
// Backpressure: bench memory throttles grant and response rate through knobs.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_3000), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory behaviour knobs.
  int gnt_pct = 100;
  int rv_pct  = 100;
  int lat_max = 0;

  // Each granted request remembers the redirect epoch it was issued in;
  // responses from an older epoch are not part of the current stream.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] fpc;
  int          epoch;
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic  redirect;
    logic  exp_req;
    logic  rv;
    mreq_t e;
    mreq_t ne;
    logic [31:0] head;
    cyc++;
    if (rst) begin
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      mem_q.delete();
      buf_q.delete();
      fpc       = 32'h0000_3000;
      epoch     = 0;
      exp_valid = 1'b0;
      exp_pc    = 32'h0;
      exp_inst  = 32'h0;
      // Stray responses during reset must be ignored.
      imem_gnt    = 1'($urandom_range(1));
      imem_rvalid = 1'($urandom_range(1));
      imem_rdata  = $urandom;
    end else begin
      chk("valid_o", 32'(valid_o), 32'(exp_valid));
      chk("pc_o", pc_o, exp_pc);
      chk("inst_o", inst_o, exp_inst);

      imem_gnt    = ($urandom_range(99) < gnt_pct);
      rv          = (mem_q.size() > 0) && (mem_q[0].ready <= cyc) && ($urandom_range(99) < rv_pct);
      imem_rvalid = rv;
      imem_rdata  = rv ? word_at(mem_q[0].addr) : 32'h0;
      #1;
      redirect = br_taken & ~pause;
      exp_req  = !redirect && ((mem_q.size() + buf_q.size()) < 4);
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, fpc);

      // Consume from what was buffered before this edge's response.
      if (redirect) begin
        exp_valid = 1'b0;
        exp_inst  = 32'h0;
        buf_q.delete();
      end else if (!pause) begin
        if (buf_q.size() > 0) begin
          head      = buf_q.pop_front();
          exp_valid = 1'b1;
          exp_pc    = head;
          exp_inst  = word_at(head);
        end else begin
          exp_valid = 1'b0;
          exp_inst  = 32'h0;
        end
      end

      if (rv) begin
        e = mem_q.pop_front();
        if (!redirect && e.epoch == epoch) buf_q.push_back(e.addr);
      end

      if (redirect) begin
        epoch++;
        fpc = br_target & 32'hFFFF_FFFC;
      end else if (exp_req && imem_gnt) begin
        ne.addr  = fpc;
        ne.epoch = epoch;
        ne.ready = cyc + 1 + int'($urandom_range(lat_max));
        mem_q.push_back(ne);
        fpc = fpc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid_o && n < 40) begin
      step();
      n++;
    end
    if (!valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: valid_o still %b after 40 cycles, required 1", name, valid_o);
    end
  endtask

  initial begin : stim
    logic [31:0] saved;

    // Reset with stray responses.
    repeat (3) step();
    chk("lit_rst_valid", 32'(valid_o), 32'd0);
    chk("lit_rst_inst", inst_o, 32'd0);
    chk("lit_rst_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("lit_first_req", 32'(imem_req), 32'd1);
    chk("lit_first_addr", imem_addr, 32'h0000_3000);

    // Zero-wait stream: first instruction at grant+3, then one per cycle.
    repeat (3) step();
    chk("lit_stream_valid", 32'(valid_o), 32'd1);
    chk("lit_stream_pc0", pc_o, 32'h0000_3000);
    chk("lit_stream_inst0", inst_o, 32'hA5A5_3000);
    step();
    chk("lit_stream_pc1", pc_o, 32'h0000_3004);
    step();
    chk("lit_stream_pc2", pc_o, 32'h0000_3008);
    repeat (10) step();

    // Stall for 6 cycles.
    @(posedge clk);
    #2;
    saved = pc_o;
    pause = 1'b1;
    repeat (6) begin
      step();
      chk("lit_stall_hold", pc_o, saved);
    end
    chk("lit_stall_full_req", 32'(imem_req), 32'd0);
    pause = 1'b0;
    step();
    chk("lit_stall_resume", pc_o, saved + 32'd4);
    repeat (5) step();

    // Redirect with responses in flight.
    @(posedge clk);
    #2 rv_pct = 0;
    repeat (2) @(posedge clk);
    #2;
    br_taken  = 1'b1;
    br_target = 32'h0000_3100;
    @(posedge clk);
    #2;
    br_taken = 1'b0;
    rv_pct   = 100;
    #1;
    chk("lit_redir_bubble", 32'(valid_o), 32'd0);
    wait_valid("redir_wait");
    chk("lit_redir_pc", pc_o, 32'h0000_3100);
    repeat (5) step();

    // Redirect during pause is ignored.
    @(posedge clk);
    #2;
    saved     = pc_o;
    pause     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_3200;
    @(posedge clk);
    #2;
    pause    = 1'b0;
    br_taken = 1'b0;
    step();
    wait_valid("paused_redir_wait");
    chk("lit_paused_redir", pc_o, saved + 32'd4);
    repeat (4) step();

    // Grant backpressure: address held, then advances by one word.
    @(posedge clk);
    #2 gnt_pct = 0;
    step();
    saved = imem_addr;
    repeat (3) begin
      step();
      chk("lit_bp_req", 32'(imem_req), 32'd1);
      chk("lit_bp_addr", imem_addr, saved);
    end
    gnt_pct = 100;
    step();
    chk("lit_bp_adv", imem_addr, saved + 32'd4);
    repeat (6) step();

    // Asynchronous reset pulse between edges.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("lit_arst_valid", 32'(valid_o), 32'd0);
    chk("lit_arst_inst", inst_o, 32'd0);
    chk("lit_arst_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    wait_valid("arst_wait");
    chk("lit_arst_restart", pc_o, 32'h0000_3000);

    // Randomized traffic.
    gnt_pct = 70;
    rv_pct  = 70;
    lat_max = 2;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #2;
      pause    = ($urandom_range(99) < 20);
      br_taken = ($urandom_range(99) < 6);
      if ($urandom_range(7) == 0) br_target = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else                        br_target = 32'h0000_3000 + 32'($urandom_range(4095));
    end

    // Address wrap with an unaligned target.
    @(posedge clk);
    #2;
    pause    = 1'b0;
    br_taken = 1'b0;
    gnt_pct  = 100;
    rv_pct   = 100;
    lat_max  = 0;
    repeat (10) @(posedge clk);
    #2;
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFB;
    @(posedge clk);
    #2 br_taken = 1'b0;
    step();
    wait_valid("wrap_wait");
    chk("lit_wrap_pc0", pc_o, 32'hFFFF_FFF8);
    step();
    chk("lit_wrap_pc1", pc_o, 32'hFFFF_FFFC);
    step();
    chk("lit_wrap_pc2", pc_o, 32'h0000_0000);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
